cfg_counter: RTL and testbench



---
 rtl/cfg_counter.sv | 71 +++++++
 tb/tb_cfg_counter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cfg_counter.sv
// Run-time configurable up/down counter with programmable terminal value,
// wrap/saturate mode, synchronous load and an enable prescaler.
module cfg_counter #(
   parameter int WIDTH   = 8,
   parameter int PRESC_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               load,
   input  logic [WIDTH-1:0]   load_val,
   input  logic               dir,
   input  logic               wrap,
   input  logic [WIDTH-1:0]   limit,
   input  logic [PRESC_W-1:0] presc,
   output logic [WIDTH-1:0]   val,
   output logic               reached,
   output logic               tc
);

   logic [PRESC_W-1:0] pc;
   logic               tick;
   logic [WIDTH:0]     step_nxt;

   // Loaded values above the terminal are clamped to the terminal.
   function automatic logic [WIDTH-1:0] sat_load(input logic [WIDTH-1:0] v,
                                                 input logic [WIDTH-1:0] lim);
      return (v > lim) ? lim : v;
   endfunction

   // Returns {terminal_event, next_val} for one prescaled step.
   function automatic logic [WIDTH:0] count_step(input logic [WIDTH-1:0] v,
                                                 input logic [WIDTH-1:0] lim,
                                                 input logic             up,
                                                 input logic             wr);
      if (up) begin
         if (v < lim)
            return {1'b0, v + 1'b1};
         return {1'b1, wr ? {WIDTH{1'b0}} : lim};
      end
      if (v != {WIDTH{1'b0}})
         return {1'b0, v - 1'b1};
      return {1'b1, wr ? lim : {WIDTH{1'b0}}};
   endfunction

   assign tick     = en && (pc == presc);
   assign step_nxt = count_step(val, limit, dir, wrap);
   assign reached  = dir ? (val == limit) : (val == {WIDTH{1'b0}});

   always_ff @(posedge clk) begin
      if (rst) begin
         val <= '0;
         pc  <= '0;
         tc  <= 1'b0;
      end else if (load) begin
         val <= sat_load(load_val, limit);
         pc  <= '0;
         tc  <= 1'b0;
      end else begin
         if (en)
            pc <= tick ? '0 : pc + 1'b1;
         if (tick) begin
            val <= step_nxt[WIDTH-1:0];
            tc  <= step_nxt[WIDTH];
         end else begin
            tc  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cfg_counter.sv
// Directed bench for cfg_counter: an 8-bit instance for the main scenarios and
// a 16-bit instance for full-range wrap and limit-lowering clamp.
module tb_cfg_counter;

   logic        clk = 1'b0;
   logic        rst, en, load, dir, wrap;
   logic [3:0]  presc;
   logic [7:0]  lv8, lim8, v8;
   logic        r8, tc8;
   logic [15:0] lv16, lim16, v16;
   logic        r16, tc16;

   int n_chk  = 0;
   int n_fail = 0;

   int t1_v[8]  = '{1, 2, 3, 4, 5, 0, 1, 2};
   int t1_tc[8] = '{0, 0, 0, 0, 0, 1, 0, 0};
   int t1_r[8]  = '{0, 0, 0, 0, 1, 0, 0, 0};
   int t2_v[5]  = '{2, 1, 0, 0, 0};
   int t2_tc[5] = '{0, 0, 0, 1, 1};
   int t2_r[5]  = '{0, 0, 1, 1, 1};

   always #5 clk = ~clk;

   cfg_counter #(.WIDTH(8), .PRESC_W(4)) u8 (
      .clk(clk), .rst(rst), .en(en), .load(load), .load_val(lv8),
      .dir(dir), .wrap(wrap), .limit(lim8), .presc(presc),
      .val(v8), .reached(r8), .tc(tc8)
   );

   cfg_counter #(.WIDTH(16), .PRESC_W(4)) u16 (
      .clk(clk), .rst(rst), .en(en), .load(load), .load_val(lv16),
      .dir(dir), .wrap(wrap), .limit(lim16), .presc(presc),
      .val(v16), .reached(r16), .tc(tc16)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; load = 1'b0; dir = 1'b0; wrap = 1'b1;
      presc = 4'd0; lv8 = 8'd0; lim8 = 8'd5; lv16 = 16'd0; lim16 = 16'hFFFF;

      // Reset state
      step();
      step();
      chk("rst_val", v8, 0);
      chk("rst_tc", tc8, 0);
      chk("rst_reached_dn", r8, 1);
      dir = 1'b1;
      #1;
      chk("rst_reached_up", r8, 0);

      // 1: up-count with wrap at limit 5
      rst = 1'b0; en = 1'b1; wrap = 1'b1; presc = 4'd0;
      for (int i = 0; i < 8; i++) begin
         step();
         chk($sformatf("t1_val%0d", i), v8, t1_v[i]);
         chk($sformatf("t1_tc%0d", i), tc8, t1_tc[i]);
         chk($sformatf("t1_rch%0d", i), r8, t1_r[i]);
      end

      // 2: load 3, then saturating down-count
      en = 1'b0; load = 1'b1; lv8 = 8'd3;
      step();
      load = 1'b0;
      chk("t2_load", v8, 3);
      chk("t2_load_tc", tc8, 0);
      dir = 1'b0; wrap = 1'b0; en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("t2_val%0d", i), v8, t2_v[i]);
         chk($sformatf("t2_tc%0d", i), tc8, t2_tc[i]);
         chk($sformatf("t2_rch%0d", i), r8, t2_r[i]);
      end

      // 3: prescaler divide-by-3 with an enable gap
      en = 1'b0; load = 1'b1; lv8 = 8'd0; lim8 = 8'd255; dir = 1'b1; wrap = 1'b1; presc = 4'd2;
      step();
      load = 1'b0; en = 1'b1;
      step(); chk("t3_a", v8, 0);
      step(); chk("t3_b", v8, 0);
      step(); chk("t3_c", v8, 1);
      step(); chk("t3_d", v8, 1);
      step(); chk("t3_e", v8, 1);
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("t3_frz%0d", i), v8, 1);
      end
      en = 1'b1;
      step(); chk("t3_resume", v8, 2);
      chk("t3_resume_tc", tc8, 0);

      // 4: load overriding a coincident terminal tick, clamped to limit
      en = 1'b0; load = 1'b1; lv8 = 8'd0;
      step();
      load = 1'b0; dir = 1'b0; wrap = 1'b1; presc = 4'd2; en = 1'b1;
      step();
      step();
      chk("t4_pre", v8, 0);
      load = 1'b1; lv8 = 8'd200; lim8 = 8'd100;
      step();
      load = 1'b0; presc = 4'd3;
      chk("t4_clamp", v8, 100);
      chk("t4_tc", tc8, 0);
      step(); chk("t4_pc1", v8, 100);
      step(); chk("t4_pc2", v8, 100);
      step(); chk("t4_pc3", v8, 100);
      step(); chk("t4_pc4", v8, 99);
      en = 1'b0; load = 1'b1; lv8 = 8'd42;
      step();
      load = 1'b0;
      chk("t4_load42", v8, 42);

      // 5: reset beats load and tick mid-count
      lv8 = 8'd7; load = 1'b1; dir = 1'b1; lim8 = 8'd255; presc = 4'd3;
      step();
      load = 1'b0; en = 1'b1;
      step();
      step();
      chk("t5_pre", v8, 7);
      rst = 1'b1; load = 1'b1; dir = 1'b0;
      step();
      chk("t5_val", v8, 0);
      chk("t5_tc", tc8, 0);
      chk("t5_rch", r8, 1);
      rst = 1'b0; load = 1'b0; dir = 1'b1;
      step(); chk("t5_pc1", v8, 0);
      step(); chk("t5_pc2", v8, 0);
      step(); chk("t5_pc3", v8, 0);
      step(); chk("t5_pc4", v8, 1);

      // 6: 16-bit full-range wrap, then clamp after lowering limit
      en = 1'b0; load = 1'b1; lv16 = 16'hFFFE; lim16 = 16'hFFFF; dir = 1'b1; wrap = 1'b1; presc = 4'd0;
      step();
      load = 1'b0; en = 1'b1;
      chk("t6_load", v16, 16'hFFFE);
      step();
      chk("t6_ffff", v16, 16'hFFFF);
      chk("t6_ffff_tc", tc16, 0);
      chk("t6_ffff_rch", r16, 1);
      step();
      chk("t6_wrap", v16, 16'h0000);
      chk("t6_wrap_tc", tc16, 1);
      en = 1'b0; load = 1'b1; lv16 = 16'h0020;
      step();
      load = 1'b0;
      chk("t6_ld20", v16, 16'h0020);
      lim16 = 16'h0010; wrap = 1'b0; en = 1'b1;
      step();
      chk("t6_clamp", v16, 16'h0010);
      chk("t6_clamp_tc", tc16, 1);
      step();
      chk("t6_sat", v16, 16'h0010);
      chk("t6_sat_tc", tc16, 1);
      en = 1'b0;
      step();
      chk("t6_idle_tc", tc16, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
